bus_dma_host: RTL and testbench

- Memory-to-memory copy engine that acts as a second bus host (initiator) on the req/gnt/rvalid bus.
- It is the counterpart of the timer and simulator-control devices. Software programs it through a small device-side register port, and it issues the read and write transactions itself.
- Sits beside the core on the bus, at host index 1. Its register window is a 1 kB device slot at 0x40000.
- Raises a level interrupt on completion.

---
 rtl/bus_dma_pkg.sv | 33 +++
 rtl/bus_dma_regs.sv | 111 +++++++++++
 rtl/bus_dma_host.sv | 143 ++++++++++++++
 tb/tb_bus_dma_host.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_dma_pkg.sv
// Shared definitions for the bus_dma_host copy engine: register word indices,
// CTRL/STATUS bit positions and the transfer state encoding.
`timescale 1ns/1ps
package bus_dma_pkg;

  // Register word indices, i.e. dev_addr_i[4:2].
  localparam logic [2:0] REG_SRC    = 3'd0;
  localparam logic [2:0] REG_DST    = 3'd1;
  localparam logic [2:0] REG_LEN    = 3'd2;
  localparam logic [2:0] REG_CTRL   = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;
  localparam logic [2:0] REG_CYCLES = 3'd5;

  localparam int CTRL_START  = 0;
  localparam int CTRL_IRQ_EN = 1;

  localparam int STATUS_BUSY = 0;
  localparam int STATUS_DONE = 1;
  localparam int STATUS_ERR  = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_WAIT = 3'd4
  } dma_state_e;

  function automatic logic reg_exists(input logic [2:0] idx);
    return idx <= REG_CYCLES;
  endfunction

endpackage

// File: rtl/bus_dma_regs.sv
// Device-side register file of bus_dma_host: decode, single-cycle response and
// status bits. The CYCLES counter exists only when BUS_DMA_HOST_PERF_EN is defined.
`timescale 1ns/1ps
module bus_dma_regs
  import bus_dma_pkg::*;
#(
  parameter int AddressWidth = 32,
  parameter int DataWidth    = 32,
  parameter int LenWidth     = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    dev_req_i,
  input  logic                    dev_we_i,
  input  logic [2:0]              idx_i,
  input  logic [DataWidth-1:0]    dev_wdata_i,
  output logic                    dev_rvalid_o,
  output logic [DataWidth-1:0]    dev_rdata_o,
  output logic                    dev_err_o,
  input  logic                    busy_i,
  input  logic                    done_set_i,
  input  logic                    err_set_i,
  output logic [AddressWidth-1:0] src_o,
  output logic [AddressWidth-1:0] dst_o,
  output logic [LenWidth-1:0]     len_o,
  output logic                    start_o,
  output logic                    irq_o
);

  logic                 wr;
  logic                 irq_en_q;
  logic                 done_q;
  logic                 err_q;
  logic [DataWidth-1:0] rdata_d;

  assign wr      = dev_req_i & dev_we_i;
  assign start_o = wr && (idx_i == REG_CTRL) && dev_wdata_i[CTRL_START] && !busy_i;
  assign irq_o   = done_q & irq_en_q;

  // NOTE: state flops use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      src_o    <= '0;
      dst_o    <= '0;
      len_o    <= '0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (wr && !busy_i) begin
        case (idx_i)
          REG_SRC: src_o <= {dev_wdata_i[AddressWidth-1:2], 2'b00};
          REG_DST: dst_o <= {dev_wdata_i[AddressWidth-1:2], 2'b00};
          REG_LEN: len_o <= dev_wdata_i[LenWidth-1:0];
          default: ;
        endcase
      end
      if (wr && idx_i == REG_CTRL) irq_en_q <= dev_wdata_i[CTRL_IRQ_EN];
      // A completion in the same cycle as a STATUS write must not be lost.
      if (done_set_i)                   done_q <= 1'b1;
      else if (wr && idx_i == REG_STATUS) done_q <= 1'b0;
      if (err_set_i)                    err_q  <= 1'b1;
      else if (wr && idx_i == REG_STATUS) err_q  <= 1'b0;
    end
  end

`ifdef BUS_DMA_HOST_PERF_EN
  logic [31:0] cycles_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                          cycles_q <= '0;
    else if (start_o)                     cycles_q <= '0;
    else if (busy_i && cycles_q != '1)    cycles_q <= cycles_q + 32'd1;
  end
`endif

  // NOTE: the default assignment up front keeps this block purely
  // combinational; a missing path would otherwise infer a latch.
  always_comb begin
    rdata_d = '0;
    case (idx_i)
      REG_SRC:    rdata_d = DataWidth'(src_o);
      REG_DST:    rdata_d = DataWidth'(dst_o);
      REG_LEN:    rdata_d = DataWidth'(len_o);
      REG_CTRL:   rdata_d[CTRL_IRQ_EN] = irq_en_q;
      REG_STATUS: begin
        rdata_d[STATUS_BUSY] = busy_i;
        rdata_d[STATUS_DONE] = done_q;
        rdata_d[STATUS_ERR]  = err_q;
      end
`ifdef BUS_DMA_HOST_PERF_EN
      REG_CYCLES: rdata_d = DataWidth'(cycles_q);
`endif
      default:    rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dev_rvalid_o <= 1'b0;
      dev_err_o    <= 1'b0;
      dev_rdata_o  <= '0;
    end else begin
      dev_rvalid_o <= dev_req_i;
      dev_err_o    <= dev_req_i && !reg_exists(idx_i);
      dev_rdata_o  <= (dev_req_i && !dev_we_i) ? rdata_d : '0;
    end
  end

endmodule

// File: rtl/bus_dma_host.sv
// Memory-to-memory copy engine acting as a bus host; one outstanding transaction.
// Optional CYCLES counter is enabled with BUS_DMA_HOST_PERF_EN.
`timescale 1ns/1ps
module bus_dma_host
  import bus_dma_pkg::*;
#(
  parameter int AddressWidth = 32,
  parameter int DataWidth    = 32,
  parameter int LenWidth     = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    dev_req_i,
  input  logic                    dev_we_i,
  input  logic [3:0]              dev_be_i,
  input  logic [AddressWidth-1:0] dev_addr_i,
  input  logic [DataWidth-1:0]    dev_wdata_i,
  output logic                    dev_rvalid_o,
  output logic [DataWidth-1:0]    dev_rdata_o,
  output logic                    dev_err_o,
  output logic                    host_req_o,
  input  logic                    host_gnt_i,
  output logic [AddressWidth-1:0] host_addr_o,
  output logic                    host_we_o,
  output logic [3:0]              host_be_o,
  output logic [DataWidth-1:0]    host_wdata_o,
  input  logic                    host_rvalid_i,
  input  logic [DataWidth-1:0]    host_rdata_i,
  input  logic                    host_err_i,
  output logic                    dma_irq_o
);

  dma_state_e            state_q, state_d;
  logic [AddressWidth-1:0] src_reg, dst_reg, src_q, dst_q;
  logic [LenWidth-1:0]     len_reg, cnt_q;
  logic [DataWidth-1:0]    data_q;
  logic                    start, busy, done_set, err_set, last_word;
  logic                    unused_bits;

  // Partial byte enables are treated as full-word writes; only [4:2] decodes.
  assign unused_bits = ^{dev_be_i, dev_addr_i[AddressWidth-1:5], dev_addr_i[1:0]};
  assign busy        = (state_q != ST_IDLE);
  assign last_word   = (cnt_q == LenWidth'(1));

  bus_dma_regs #(
    .AddressWidth(AddressWidth),
    .DataWidth   (DataWidth),
    .LenWidth    (LenWidth)
  ) u_regs (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .dev_req_i   (dev_req_i),
    .dev_we_i    (dev_we_i),
    .idx_i       (dev_addr_i[4:2]),
    .dev_wdata_i (dev_wdata_i),
    .dev_rvalid_o(dev_rvalid_o),
    .dev_rdata_o (dev_rdata_o),
    .dev_err_o   (dev_err_o),
    .busy_i      (busy),
    .done_set_i  (done_set),
    .err_set_i   (err_set),
    .src_o       (src_reg),
    .dst_o       (dst_reg),
    .len_o       (len_reg),
    .start_o     (start),
    .irq_o       (dma_irq_o)
  );

  // host_req_o decodes straight from this register, so reset drops it at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start && len_reg != '0) state_d = ST_RD_REQ;
      ST_RD_REQ:  if (host_gnt_i) state_d = ST_RD_WAIT;
      ST_RD_WAIT: if (host_rvalid_i) state_d = host_err_i ? ST_IDLE : ST_WR_REQ;
      ST_WR_REQ:  if (host_gnt_i) state_d = ST_WR_WAIT;
      ST_WR_WAIT: if (host_rvalid_i) state_d = (host_err_i || last_word) ? ST_IDLE : ST_RD_REQ;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    host_req_o   = 1'b0;
    host_we_o    = 1'b0;
    host_be_o    = 4'h0;
    host_addr_o  = '0;
    host_wdata_o = '0;
    done_set     = 1'b0;
    err_set      = 1'b0;
    case (state_q)
      ST_IDLE: done_set = start && (len_reg == '0);
      ST_RD_REQ: begin
        host_req_o  = 1'b1;
        host_be_o   = 4'hF;
        host_addr_o = src_q;
      end
      ST_RD_WAIT: begin
        done_set = host_rvalid_i && host_err_i;
        err_set  = host_rvalid_i && host_err_i;
      end
      ST_WR_REQ: begin
        host_req_o   = 1'b1;
        host_we_o    = 1'b1;
        host_be_o    = 4'hF;
        host_addr_o  = dst_q;
        host_wdata_o = data_q;
      end
      ST_WR_WAIT: begin
        done_set = host_rvalid_i && (host_err_i || last_word);
        err_set  = host_rvalid_i && host_err_i;
      end
      default: ;
    endcase
  end

  // Working copies; the programmed SRC/DST/LEN registers are never modified.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      src_q  <= '0;
      dst_q  <= '0;
      cnt_q  <= '0;
      data_q <= '0;
    end else begin
      if (state_q == ST_IDLE && start && len_reg != '0) begin
        src_q <= src_reg;
        dst_q <= dst_reg;
        cnt_q <= len_reg;
      end
      if (state_q == ST_RD_WAIT && host_rvalid_i) data_q <= host_rdata_i;
      if (state_q == ST_WR_WAIT && host_rvalid_i && !host_err_i) begin
        src_q <= src_q + AddressWidth'(4);
        dst_q <= dst_q + AddressWidth'(4);
        cnt_q <= cnt_q - LenWidth'(1);
      end
    end
  end

endmodule

// File: tb/tb_bus_dma_host.sv
// Self-checking bench for bus_dma_host: randomized copies against a memory model
// and an expected-transaction list derived from SRC/DST/LEN.
`timescale 1ns/1ps
module tb_bus_dma_host;

  localparam logic [2:0] R_SRC = 3'd0, R_DST = 3'd1, R_LEN = 3'd2;
  localparam logic [2:0] R_CTRL = 3'd3, R_STATUS = 3'd4, R_CYCLES = 3'd5;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        dev_req_i, dev_we_i;
  logic [3:0]  dev_be_i;
  logic [31:0] dev_addr_i, dev_wdata_i;
  logic        dev_rvalid_o, dev_err_o;
  logic [31:0] dev_rdata_o;
  logic        host_req_o, host_gnt_i, host_we_o;
  logic [31:0] host_addr_o, host_wdata_o;
  logic [3:0]  host_be_o;
  logic        host_rvalid_i, host_err_i;
  logic [31:0] host_rdata_i;
  logic        dma_irq_o;

  bus_dma_host dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .dev_req_i(dev_req_i), .dev_we_i(dev_we_i), .dev_be_i(dev_be_i),
    .dev_addr_i(dev_addr_i), .dev_wdata_i(dev_wdata_i),
    .dev_rvalid_o(dev_rvalid_o), .dev_rdata_o(dev_rdata_o), .dev_err_o(dev_err_o),
    .host_req_o(host_req_o), .host_gnt_i(host_gnt_i), .host_addr_o(host_addr_o),
    .host_we_o(host_we_o), .host_be_o(host_be_o), .host_wdata_o(host_wdata_o),
    .host_rvalid_i(host_rvalid_i), .host_rdata_i(host_rdata_i), .host_err_i(host_err_i),
    .dma_irq_o(dma_irq_o)
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } tx_t;

  // Bus-side memory and responder state.
  logic [31:0] mem [bit [31:0]];
  tx_t         tx_log[$];
  int          gnt_delay = 0, resp_extra_max = 0, err_on_read = 0, reads_seen = 0;
  int          req_cycles = 0;
  bit          hold_writes = 1'b0;

  // Model of the programmed transfer.
  logic [31:0] cur_src, cur_dst;
  int          cur_len;
  logic [31:0] exp_words[$];

  initial begin : responder
    int          stall;
    bit          resp_pending;
    int          resp_wait;
    logic [31:0] resp_data;
    bit          resp_err;
    logic [31:0] held_addr, held_wdata;
    logic        held_we;
    stall = 0; resp_pending = 0; resp_wait = 0; resp_data = '0; resp_err = 0;
    held_addr = '0; held_wdata = '0; held_we = 1'b0;
    host_gnt_i = 0; host_rvalid_i = 0; host_err_i = 0; host_rdata_i = '0;
    forever begin
      @(negedge clk_i);
      host_gnt_i = 0; host_rvalid_i = 0; host_err_i = 0; host_rdata_i = '0;
      if (!rst_ni) begin
        stall = 0; resp_pending = 0;
        continue;
      end
      if (resp_pending) begin
        if (resp_wait == 0) begin
          host_rvalid_i = 1; host_rdata_i = resp_data; host_err_i = resp_err;
          resp_pending = 0;
          check("req_with_rvalid", host_req_o, 1'b0);
        end else begin
          resp_wait--;
          check("req_while_outstanding", host_req_o, 1'b0);
        end
      end else if (host_req_o) begin
        req_cycles++;
        if (stall == 0) begin
          held_addr = host_addr_o; held_we = host_we_o; held_wdata = host_wdata_o;
          check("host_be", host_be_o, 4'hF);
        end else begin
          check("stall_addr", host_addr_o, held_addr);
          check("stall_we", host_we_o, held_we);
          if (held_we) check("stall_wdata", host_wdata_o, held_wdata);
        end
        if (stall >= gnt_delay && !(hold_writes && host_we_o)) begin
          host_gnt_i = 1;
          stall = 0;
          tx_log.push_back('{we: host_we_o, addr: host_addr_o, data: host_wdata_o});
          resp_err = 0;
          resp_data = '0;
          if (host_we_o) begin
            mem[host_addr_o] = host_wdata_o;
          end else begin
            reads_seen++;
            resp_data = mem.exists(host_addr_o) ? mem[host_addr_o] : (32'hBAD0_0000 ^ host_addr_o);
            resp_err  = (reads_seen == err_on_read);
          end
          resp_pending = 1;
          resp_wait = $urandom_range(resp_extra_max, 0);
        end else begin
          stall++;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic reg_write(input logic [2:0] idx, input logic [31:0] data, input logic [3:0] be);
    @(negedge clk_i);
    dev_req_i = 1; dev_we_i = 1; dev_be_i = be;
    dev_addr_i = 32'h0004_0000 + {27'd0, idx, 2'b00}; dev_wdata_i = data;
    @(negedge clk_i);
    dev_req_i = 0; dev_we_i = 0;
    check("wr_rvalid", dev_rvalid_o, 1'b1);
  endtask

  task automatic reg_read(input logic [2:0] idx, output logic [31:0] data, output logic err);
    @(negedge clk_i);
    dev_req_i = 1; dev_we_i = 0; dev_be_i = 4'hF;
    dev_addr_i = 32'h0004_0000 + {27'd0, idx, 2'b00}; dev_wdata_i = '0;
    @(negedge clk_i);
    dev_req_i = 0;
    check("rd_rvalid", dev_rvalid_o, 1'b1);
    data = dev_rdata_o;
    err  = dev_err_o;
  endtask

  task automatic read_expect(input string tag, input logic [2:0] idx, input logic [31:0] exp);
    logic [31:0] d;
    logic        e;
    reg_read(idx, d, e);
    check(tag, d, exp);
  endtask

  task automatic start_copy(input logic [31:0] src, input logic [31:0] dst, input int len,
                            input logic irq_en);
    logic [31:0] w;
    cur_src = src; cur_dst = dst; cur_len = len;
    exp_words.delete();
    for (int i = 0; i < len; i++) begin
      w = $urandom;
      mem[src + 32'(4 * i)] = w;
      exp_words.push_back(w);
    end
    tx_log.delete();
    reads_seen = 0;
    reg_write(R_STATUS, 32'h0, 4'hF);
    reg_write(R_SRC, src, 4'hF);
    reg_write(R_DST, dst, 4'hF);
    reg_write(R_LEN, 32'(len), 4'hF);
    reg_write(R_CTRL, {30'd0, irq_en, 1'b1}, 4'hF);
  endtask

  task automatic wait_idle();
    logic [31:0] st;
    logic        e;
    int          n;
    n = 0;
    do begin
      reg_read(R_STATUS, st, e);
      n++;
    end while (st[0] && n < 2000);
    check("idle_timeout", {31'd0, st[0]}, 32'd0);
  endtask

  task automatic verify_copy(input string tag);
    logic [31:0] sa, da;
    check({tag, "_tx_count"}, tx_log.size(), 2 * cur_len);
    for (int i = 0; i < cur_len; i++) begin
      sa = cur_src + 32'(4 * i);
      da = cur_dst + 32'(4 * i);
      if (2 * i + 1 < tx_log.size()) begin
        check({tag, "_rd_we"}, tx_log[2*i].we, 1'b0);
        check({tag, "_rd_addr"}, tx_log[2*i].addr, sa);
        check({tag, "_wr_we"}, tx_log[2*i+1].we, 1'b1);
        check({tag, "_wr_addr"}, tx_log[2*i+1].addr, da);
        check({tag, "_wr_data"}, tx_log[2*i+1].data, exp_words[i]);
      end
      check({tag, "_mem"}, mem.exists(da) ? mem[da] : 32'hDEAD_BEEF, exp_words[i]);
    end
    read_expect({tag, "_status"}, R_STATUS, 32'h2);
  endtask

  initial begin : main
    logic [31:0] d;
    logic        e;
    int          n;
    rst_ni = 0;
    dev_req_i = 0; dev_we_i = 0; dev_be_i = '0; dev_addr_i = '0; dev_wdata_i = '0;
    repeat (3) @(negedge clk_i);
    check("rst_host_req", host_req_o, 1'b0);
    check("rst_host_addr", host_addr_o, 32'h0);
    check("rst_host_be", host_be_o, 4'h0);
    check("rst_dev_rvalid", dev_rvalid_o, 1'b0);
    check("rst_irq", dma_irq_o, 1'b0);
    rst_ni = 1;

    // Basic zero-wait copy with interrupt enabled.
    gnt_delay = 0; resp_extra_max = 0;
    start_copy(32'h0010_0000, 32'h0010_0400, 4, 1'b1);
    wait_idle();
    verify_copy("basic");
    check("basic_irq", dma_irq_o, 1'b1);
`ifdef BUS_DMA_HOST_PERF_EN
    read_expect("cycles", R_CYCLES, 32'd16);
`else
    read_expect("cycles_absent", R_CYCLES, 32'd0);
`endif
    reg_write(R_STATUS, 32'h0, 4'hF);
    check("irq_cleared", dma_irq_o, 1'b0);
    read_expect("status_cleared", R_STATUS, 32'h0);

    // Backpressure plus register writes while busy.
    gnt_delay = 3;
    start_copy(32'h0010_0000, 32'h0010_0800, 4, 1'b0);
    reg_write(R_SRC, 32'hDEAD_0000, 4'hF);
    reg_write(R_LEN, 32'd9, 4'hF);
    read_expect("src_busy_ignored", R_SRC, 32'h0010_0000);
    read_expect("len_busy_ignored", R_LEN, 32'd4);
    wait_idle();
    verify_copy("stall");
    check("irq_disabled", dma_irq_o, 1'b0);

    // LEN=0: DONE one cycle after the START write, no bus traffic.
    gnt_delay = 0;
    reg_write(R_STATUS, 32'h0, 4'hF);
    reg_write(R_LEN, 32'h0, 4'hF);
    req_cycles = 0;
    tx_log.delete();
    reg_write(R_CTRL, 32'h3, 4'hF);
    check("len0_irq", dma_irq_o, 1'b1);
    repeat (5) @(negedge clk_i);
    check("len0_no_req", req_cycles, 0);
    read_expect("len0_status", R_STATUS, 32'h2);

    // Bus error on the second read response.
    err_on_read = 2;
    start_copy(32'h0020_0000, 32'h0020_0400, 4, 1'b0);
    wait_idle();
    err_on_read = 0;
    check("err_tx_count", tx_log.size(), 3);
    check("err_one_write", mem.exists(32'h0020_0400) ? mem[32'h0020_0400] : 32'hDEAD_BEEF,
          exp_words[0]);
    check("err_no_second_write", {31'd0, mem.exists(32'h0020_0404)}, 32'd0);
    read_expect("err_status", R_STATUS, 32'h6);
    read_expect("err_src_kept", R_SRC, 32'h0020_0000);
    read_expect("err_dst_kept", R_DST, 32'h0020_0400);
    read_expect("err_len_kept", R_LEN, 32'd4);

    // Register corner cases.
    reg_read(3'd7, d, e);
    check("off1c_err", e, 1'b1);
    check("off1c_rdata", d, 32'h0);
    reg_read(3'd6, d, e);
    check("off18_err", e, 1'b1);
    reg_write(R_SRC, 32'h0012_3457, 4'h1);
    read_expect("src_align_partial_be", R_SRC, 32'h0012_3454);

    // Destination wrap past the top of the address space.
    start_copy(32'h0030_0000, 32'hFFFF_FFFC, 2, 1'b0);
    wait_idle();
    verify_copy("wrap");
    if (tx_log.size() == 4) check("wrap_addr0", tx_log[3].addr, 32'h0);

    // Randomized copies under random grant and response latency.
    resp_extra_max = 2;
    for (int it = 0; it < 6; it++) begin
      gnt_delay = $urandom_range(3, 0);
      start_copy(32'h1000_0000 + ($urandom_range(255, 0) << 2),
                 32'h2000_0000 + ($urandom_range(255, 0) << 2),
                 $urandom_range(6, 1), 1'b1);
      wait_idle();
      verify_copy("rand");
    end

    // Reset while a write request waits for its grant.
    gnt_delay = 0; resp_extra_max = 0; hold_writes = 1;
    start_copy(32'h0040_0000, 32'h0040_0400, 1, 1'b1);
    n = 0;
    while (!(host_req_o && host_we_o) && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    check("reach_wr_req", {31'd0, host_req_o && host_we_o}, 32'd1);
    #2 rst_ni = 0;
    #1 check("rst_req_drop", host_req_o, 1'b0);
    @(negedge clk_i);
    hold_writes = 0;
    rst_ni = 1;
    for (int r = 0; r < 6; r++) read_expect("post_rst_reg", 3'(r), 32'h0);
    check("post_rst_irq", dma_irq_o, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
